// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared definitions for the serial sequence family (transmitter and the
// detectors it feeds).
//   seq_state_e : state encoding, identical across the family so that state
//                 values line up when transmitter and detector are probed
//                 side by side.
//   PAT_1011    : default 4-bit pattern used by the family's reference setups.
// -----------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        GAP  = 2'b10,
        FIN  = 2'b11
    } seq_state_e;

    localparam logic [3:0] PAT_1011 = 4'b1011;

endpackage

// File: rtl/seq_shift_ld.sv
// -----------------------------------------------------------------------------
// seq_shift_ld
// Loadable PAT_W-bit shift register, MSB first.
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-low
//   ld   : load din (has priority over sh)
//   sh   : shift left by one, zero fill
//   din  : parallel load value
//   sout : serial out, current MSB
// -----------------------------------------------------------------------------
module seq_shift_ld #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             sh,
    input  logic [PAT_W-1:0] din,
    output logic             sout
);

    logic [PAT_W-1:0] sr_q;
    logic [PAT_W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (ld) begin
            sr_d = din;
        end else if (sh) begin
            sr_d = {sr_q[PAT_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sout = sr_q[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// -----------------------------------------------------------------------------
// seq_pattern_tx
// Serial pattern transmitter: sends a captured PAT_W-bit pattern MSB first,
// rep times, with gap idle cycles between frames, then pulses done.
//   clk     : clock, rising edge
//   rst     : asynchronous reset, active-low
//   start   : burst request, only honoured in IDLE
//   pattern : frame bits, captured on accepted start
//   rep     : number of frames, captured on accepted start (0 = none)
//   gap     : idle cycles between frames, captured on accepted start
//   seq     : serial data (registered)
//   seq_vld : seq carries a frame bit
//   busy    : burst in progress, through the done cycle
//   done    : one-cycle pulse at burst end
// Build option: define SEQ_PATTERN_TX_PARITY_EN to append an even-parity bit
// to every frame (frame length PAT_W+1).
// -----------------------------------------------------------------------------
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int REP_W = 4,
    parameter int GAP_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [REP_W-1:0] rep,
    input  logic [GAP_W-1:0] gap,
    output logic             seq,
    output logic             seq_vld,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(PAT_W + 1);
`ifdef SEQ_PATTERN_TX_PARITY_EN
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAT_W);
`else
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAT_W - 1);
`endif

    seq_state_e       state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [REP_W-1:0] frm_q, frm_d;
    logic [GAP_W-1:0] gap_sh_q, gap_sh_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             seq_q, seq_d;
    logic             seq_vld_q, seq_vld_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept;
    logic             frame_end;
    logic             frm_more;
    logic             gap_exit;
    logic             frame_start;
    logic [PAT_W-1:0] frame_src;
    logic             sr_ld;
    logic             sr_sh;
    logic [PAT_W-1:0] sr_din;
    logic             sr_out;

    assign accept    = (state_q == IDLE) && start;
    assign frame_end = (state_q == SEND) && (bit_cnt_q == LAST_IDX);
    assign frm_more  = (frm_q != REP_W'(1));
    assign gap_exit  = (state_q == GAP) && (gap_cnt_q == GAP_W'(1));

    // Edges at which the first bit of a frame is issued. The first bit goes
    // straight into seq_q, so the shift register is loaded with the remaining
    // bits and its MSB is always the next bit to send.
    assign frame_start = (accept && (rep != '0))
                       || (frame_end && frm_more && (gap_sh_q == '0))
                       || gap_exit;
    assign frame_src   = accept ? pattern : pat_q;
    assign sr_ld       = frame_start;
    assign sr_sh       = (state_q == SEND) && !frame_end;
    assign sr_din      = {frame_src[PAT_W-2:0], 1'b0};

    seq_shift_ld #(
        .PAT_W (PAT_W)
    ) u_shift (
        .clk  (clk),
        .rst  (rst),
        .ld   (sr_ld),
        .sh   (sr_sh),
        .din  (sr_din),
        .sout (sr_out)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (rep == '0) ? FIN : SEND;
                end
            end
            SEND: begin
                if (frame_end) begin
                    if (!frm_more) begin
                        state_d = FIN;
                    end else if (gap_sh_q != '0) begin
                        state_d = GAP;
                    end else begin
                        state_d = SEND;
                    end
                end
            end
            GAP: begin
                if (gap_exit) begin
                    state_d = SEND;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Shadow registers and counters
    always_comb begin
        pat_d     = pat_q;
        frm_d     = frm_q;
        gap_sh_d  = gap_sh_q;
        gap_cnt_d = gap_cnt_q;
        bit_cnt_d = bit_cnt_q;

        if (accept) begin
            pat_d    = pattern;
            frm_d    = rep;
            gap_sh_d = gap;
        end

        if (frame_start) begin
            bit_cnt_d = '0;
        end else if ((state_q == SEND) && !frame_end) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end

        if (frame_end) begin
            frm_d = frm_q - REP_W'(1);
        end

        if (frame_end && frm_more) begin
            gap_cnt_d = gap_sh_q;
        end else if (state_q == GAP) begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
    end

    // Output logic: next value of each registered output
    always_comb begin
        seq_d     = 1'b0;
        seq_vld_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        if (frame_start) begin
            seq_d     = frame_src[PAT_W-1];
            seq_vld_d = 1'b1;
            busy_d    = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    // rep==0: skip straight to the done cycle
                    if (accept) begin
                        busy_d = 1'b1;
                        done_d = 1'b1;
                    end
                end
                SEND: begin
                    if (!frame_end) begin
                        seq_vld_d = 1'b1;
                        busy_d    = 1'b1;
`ifdef SEQ_PATTERN_TX_PARITY_EN
                        seq_d = (bit_cnt_q == CNT_W'(PAT_W - 1)) ? ^pat_q : sr_out;
`else
                        seq_d = sr_out;
`endif
                    end else if (!frm_more) begin
                        busy_d = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        busy_d = 1'b1;
                    end
                end
                GAP: begin
                    busy_d = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_q     <= '0;
            frm_q     <= '0;
            gap_sh_q  <= '0;
            gap_cnt_q <= '0;
            bit_cnt_q <= '0;
            seq_q     <= 1'b0;
            seq_vld_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            pat_q     <= pat_d;
            frm_q     <= frm_d;
            gap_sh_q  <= gap_sh_d;
            gap_cnt_q <= gap_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            seq_q     <= seq_d;
            seq_vld_q <= seq_vld_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign seq     = seq_q;
    assign seq_vld = seq_vld_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
